// File: rtl/str_fifo.sv
// Byte-stream FIFO with valid/ready handshakes on both sides, first-word fall-through output,
// and registered fill-level, ready, valid and almost-full flags.
module str_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4,
  parameter int unsigned AF = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic [AW:0]   cnt,
  output logic          afull
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          s_tready_q, s_tready_d;
  logic          m_tvalid_q, m_tvalid_d;
  logic          afull_q, afull_d;
  logic [DW-1:0] m_tdata_q, m_tdata_d;

  logic push_c;
  logic pop_c;

  assign push_c = s_tvalid & s_tready_q;
  assign pop_c  = m_tvalid_q & m_tready;

  // Next pointers, level, flags and the next head word presented on m_tdata.
  always_comb begin
    wptr_d     = wptr_q + PW'(push_c);
    rptr_d     = rptr_q + PW'(pop_c);
    cnt_d      = cnt_q + PW'(push_c) - PW'(pop_c);
    s_tready_d = (cnt_d != PW'(DEPTH));
    m_tvalid_d = (cnt_d != PW'(0));
    afull_d    = (cnt_d >= PW'(AF));
    // When the new head is the slot being written this edge, forward the incoming word.
    if (push_c && (rptr_d == wptr_q)) begin
      m_tdata_d = s_tdata;
    end else begin
      m_tdata_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      afull_q    <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      afull_q    <= afull_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q[AW-1:0]] <= s_tdata;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign cnt      = cnt_q;
  assign afull    = afull_q;

endmodule

// File: tb/tb_str_fifo.sv
// Directed and randomized checks of str_fifo: reset, single word, fill/drain with wrap,
// simultaneous push/pop, queue-scoreboarded random traffic and mid-stream reset.
module tb_str_fifo;

  logic       clk;
  logic       rst_n;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [4:0] cnt;
  logic       afull;

  int total;
  int bad;

  str_fifo #(.DW(8), .AW(4), .AF(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .cnt      (cnt),
    .afull    (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) step();
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    total++; if (cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", afull); end
    rst_n = 1'b1;
    #1;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL release_s_tready_early got=%b exp=0", s_tready); end
    @(negedge clk);
    step();
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_s_tready got=%b exp=1", s_tready); end
  endtask

  task automatic test_single();
    s_tvalid = 1'b1; s_tdata = 8'ha5;
    step();
    s_tvalid = 1'b0;
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL single_m_tvalid got=%b exp=1", m_tvalid); end
    total++; if (m_tdata !== 8'ha5) begin bad++; $display("FAIL single_m_tdata got=%h exp=a5", m_tdata); end
    total++; if (cnt !== 5'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", cnt); end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single_pop_m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (cnt !== 5'd0) begin bad++; $display("FAIL single_pop_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_fill();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL fill_ready_before i=%0d got=%b exp=1", i, s_tready); end
      s_tvalid = 1'b1; s_tdata = 8'(i);
      step();
      total++; if (cnt !== 5'(i + 1)) begin bad++; $display("FAIL fill_cnt i=%0d got=%0d exp=%0d", i, cnt, i + 1); end
      total++; if (afull !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, afull, (i + 1 >= 12)); end
      total++; if (s_tready !== (i + 1 != 16)) begin bad++; $display("FAIL fill_s_tready i=%0d got=%b exp=%b", i, s_tready, (i + 1 != 16)); end
    end
    s_tdata = 8'h10;
    step();
    step();
    total++; if (cnt !== 5'd16) begin bad++; $display("FAIL fill_held_cnt got=%0d exp=16", cnt); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL fill_held_ready got=%b exp=0", s_tready); end
    total++; if (m_tdata !== 8'h00) begin bad++; $display("FAIL fill_head got=%h exp=00", m_tdata); end
    s_tvalid = 1'b0;
  endtask

  task automatic test_drain_wrap();
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
          s_tvalid = 1'b1; s_tdata = 8'(r * 16 + i);
          step();
        end
        s_tvalid = 1'b0;
        total++; if (cnt !== 5'd16) begin bad++; $display("FAIL wrap_full_cnt round=%0d got=%0d exp=16", r, cnt); end
      end
      m_tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'(r * 16 + i))
          begin bad++; $display("FAIL drain_data round=%0d i=%0d got=%b/%h exp=1/%h", r, i, m_tvalid, m_tdata, 8'(r * 16 + i)); end
        step();
      end
      m_tready = 1'b0;
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL drain_empty round=%0d got=%b exp=0", r, m_tvalid); end
      total++; if (cnt !== 5'd0) begin bad++; $display("FAIL drain_cnt round=%0d got=%0d exp=0", r, cnt); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] q[$];
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'h20 + i);
      q.push_back(s_tdata);
      step();
    end
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      total++; if (cnt !== 5'd5) begin bad++; $display("FAIL simul_cnt i=%0d got=%0d exp=5", i, cnt); end
      total++; if (m_tdata !== q[0]) begin bad++; $display("FAIL simul_data i=%0d got=%h exp=%h", i, m_tdata, q[0]); end
      s_tdata = 8'(8'h25 + i);
      void'(q.pop_front());
      q.push_back(s_tdata);
      step();
    end
    m_tready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      s_tdata = 8'(8'h80 + i);
      q.push_back(s_tdata);
      step();
    end
    total++; if (cnt !== 5'd16 || s_tready !== 1'b0) begin bad++; $display("FAIL simul_full got=%0d/%b exp=16/0", cnt, s_tready); end
    s_tdata = 8'hee;
    m_tready = 1'b1;
    void'(q.pop_front());
    step();
    s_tvalid = 1'b0; m_tready = 1'b0;
    total++; if (cnt !== 5'd15) begin bad++; $display("FAIL full_pushpop_cnt got=%0d exp=15", cnt); end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL full_pushpop_ready got=%b exp=1", s_tready); end
    m_tready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      total++; if (m_tdata !== q[0]) begin bad++; $display("FAIL full_drain_data i=%0d got=%h exp=%h", i, m_tdata, q[0]); end
      void'(q.pop_front());
      step();
    end
    m_tready = 1'b0;
    total++; if (cnt !== 5'd0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL simul_end got=%0d/%b exp=0/0", cnt, m_tvalid); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int sent, rcvd, cyc;
    logic push, pop, held;
    sent = 0; rcvd = 0; cyc = 0; held = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    while (rcvd < 10000 && cyc < 80000) begin
      total++; if (cnt !== 5'(q.size())) begin bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, cnt, q.size()); end
      total++; if (s_tready !== (q.size() != 16)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b", cyc, s_tready); end
      total++; if (m_tvalid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b", cyc, m_tvalid); end
      total++; if (afull !== (q.size() >= 12)) begin bad++; $display("FAIL rand_afull cyc=%0d got=%b", cyc, afull); end
      if (q.size() != 0) begin
        total++; if (m_tdata !== q[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, m_tdata, q[0]); end
      end
      if (!held) begin
        if (sent < 10000) begin
          s_tvalid = 1'($urandom_range(0, 1));
          s_tdata  = 8'($urandom_range(0, 255));
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = 1'($urandom_range(0, 1));
      push = s_tvalid && (q.size() != 16);
      pop  = m_tready && (q.size() != 0);
      step();
      cyc++;
      if (pop) begin void'(q.pop_front()); rcvd++; end
      if (push) begin q.push_back(s_tdata); sent++; end
      held = s_tvalid && !push;
    end
    total++; if (rcvd != 10000) begin bad++; $display("FAIL rand_timeout got=%0d words exp=10000", rcvd); end
    s_tvalid = 1'b0; m_tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(8'hc0 + i);
      step();
    end
    s_tvalid = 1'b0;
    total++; if (cnt !== 5'd7) begin bad++; $display("FAIL mid_pre_cnt got=%0d exp=7", cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || cnt !== 5'd0) begin bad++; $display("FAIL mid_async got=%b/%0d exp=0/0", m_tvalid, cnt); end
    total++; if (s_tready !== 1'b0 || afull !== 1'b0) begin bad++; $display("FAIL mid_async_flags got=%b/%b exp=0/0", s_tready, afull); end
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    total++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || cnt !== 5'd0)
      begin bad++; $display("FAIL mid_after got=%b/%b/%0d exp=1/0/0", s_tready, m_tvalid, cnt); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
